// File: rtl/arb_mux_rr_pkg.sv
// rtl/arb_mux_rr_pkg.sv - shared datapath constants and types for the arbitrating mux
package arb_mux_rr_pkg;

    localparam int DATA_W = 32;
    localparam int MAX_CH = 16;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rtl/arb_mux_rr_arbiter.sv - round-robin / fixed-priority one-hot arbiter
module arb_mux_rr_arbiter
    import arb_mux_rr_pkg::*;
#(
    parameter int N          = 4,
    parameter int FIXED_PRIO = 0,
    parameter int SELW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [SELW-1:0] gnt_idx_o
);

    // Scan from the start channel, wrapping modulo N, and grant the first requester
    always_comb begin
        int              start;
        int              idx;
        logic            found;
        logic [SELW-1:0] idx_s;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        idx_s     = '0;
        start     = (FIXED_PRIO != 0) ? 0 : int'(ptr_i);
        // Pointer values beyond N-1 cannot occur; fall back to channel 0 anyway
        if (start >= N) begin
            start = 0;
        end
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < N && !found) begin
                idx = start + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                idx_s = SELW'(idx);
                if (en_i && req_i[idx_s]) begin
                    found          = 1'b1;
                    gnt_o[idx_s]   = 1'b1;
                    gnt_idx_o      = idx_s;
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux_rr.sv
// rtl/arb_mux_rr.sv - N-channel arbitrating word mux with registered valid/ready output
module arb_mux_rr
    import arb_mux_rr_pkg::*;
#(
    parameter int WIDTH      = DATA_W,
    parameter int N          = 4,
    parameter int FIXED_PRIO = 0,
    parameter int SELW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [N-1:0]       in_valid_i,
    input  logic [N*WIDTH-1:0] in_data_i,
    output logic [N-1:0]       in_ready_o,
    output logic               out_valid_o,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [SELW-1:0]    out_sel_o,
    input  logic               out_ready_i
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             load;
    logic             arb_en;
    logic [N-1:0]     gnt;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] sel_data;

    // The output register can take a word when empty or being drained this cycle;
    // arbitration is also held off while reset is asserted so in_ready stays low
    assign load   = !out_valid_q || out_ready_i;
    assign arb_en = load && rst_n_i;

    arb_mux_rr_arbiter #(
        .N          (N),
        .FIXED_PRIO (FIXED_PRIO),
        .SELW       (SELW)
    ) u_arbiter (
        .req_i     (in_valid_i),
        .ptr_i     (rr_ptr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign in_ready_o = gnt;

    // AND-OR select from the one-hot grant so no out-of-range slice is ever formed
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | in_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for the output register and the round-robin pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = |gnt;
            if (|gnt) begin
                out_data_d = sel_data;
                out_sel_d  = gnt_idx;
                if (FIXED_PRIO == 0) begin
                    rr_ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
                end
            end
        end
    end

    // State registers; reset discards any pending word and rewinds the pointer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: doc/arb_mux_rr.md
Name: arb_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output stage.
- Replaces fixed-select combinational word muxes wherever several producers share one consumer, e.g. writeback source selection or memory-port sharing in the multicycle/pipelined datapath.
- Each input channel has a valid/ready handshake. A round-robin or fixed-priority arbiter picks one channel per transfer. The chosen word, and the index of its channel, are held in an output register with a valid/ready handshake.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- N, 4, number of input channels (2..16).
- SELW, $clog2(N), width of the channel index (derived; not overridden).
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = fixed priority with channel 0 highest.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request; bit i = channel i.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts the output word.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready=0 while rst_n is low.
- load = !out_valid || out_ready. The output register may capture a new word this cycle.
- Grant, combinational:
  - No grant if load=0 or in_valid=0.
  - FIXED_PRIO=0: grant goes to the first channel with in_valid set, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo N.
  - FIXED_PRIO=1: grant goes to the lowest-index valid channel.
- in_ready = one-hot grant vector. A transfer on channel i is in_valid[i] && in_ready[i].
- On a clock edge with a grant to channel g:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - If FIXED_PRIO=0, rr_ptr <= (g==N-1) ? 0 : g+1. Wrap is explicit; N need not be a power of 2.
- On an edge with load=1 and no grant: out_valid <= 0. out_data and out_sel hold their previous values.
- On an edge with load=0 (out_valid=1, out_ready=0): all registers hold and in_ready=0. Stall is backpressure-safe; no word is dropped or duplicated.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one word per cycle while out_ready=1, including simultaneous drain and refill in the same cycle.
- rr_ptr changes only on a grant. Idle cycles do not rotate priority.
- in_ready must not depend combinationally on in_data. It depends on in_valid, out_valid, out_ready and rr_ptr.
- No X is ever driven. An index outside 0..N-1 is unreachable by construction, and any case/default path drives zeros.
- Reset mid-transfer: the pending output word is discarded and rr_ptr returns to 0. The consumer must not see out_valid during or immediately after reset until a new grant occurs.
- Input-side rule: once a producer asserts in_valid it holds it until accepted. Fairness depends on this rule but the block does not check it.

Decomposition:
- Shared package (datapath_pkg):
  - Constant DATA_W=32.
  - Typedef word_t for the data word.
  - Localparam MAX_CH=16.
- Natural sub-module: rr_arbiter (N, FIXED_PRIO). Inputs: req[N], ptr[SELW], en. Outputs: one-hot gnt[N] and encoded gnt_idx[SELW].
- arb_mux_rr instantiates rr_arbiter and contains the output register and the pointer update.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1111 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0. Release -> first grant goes to ch0 on the next edge.
- Round-robin fairness (WIDTH=32, N=4): hold in_valid=1111 with data ch_i=32'hA0+i and out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, out_data 0xA0..0xA3 repeating, in_ready one-hot every cycle.
- Pointer wrap and skipping: rr_ptr=3 (after a grant to ch2), in_valid=0101 -> grant ch0, then ch2. With N=3, in_valid=100 repeatedly -> rr_ptr cycles 0 and stays in range.
- Backpressure: out_valid=1 holding 0xA1, out_ready=0 for 3 cycles with in_valid=1111 -> out_data stays 0xA1 and in_ready=0000. Raise out_ready -> the next word is captured in the same cycle, with no gap and no duplicate.
- Fixed priority (FIXED_PRIO=1): in_valid=1110 held with out_ready=1 -> out_sel=1 every cycle. Drop bit 1 -> out_sel=2.
- Async reset mid-stream: pulse rst_n low between clock edges while out_valid=1 -> out_valid drops immediately, rr_ptr=0, and the next grant after release is ch0.
